// File: rtl/fanin_req_rr_arb_buffered.sv
// ---------------------------------------------------------------------------
// fanin_req_rr_arb_buffered
//
// N_CH-to-1 request fan-in for the TCDM/L2 crossbar bridge. A round-robin
// arbiter picks one requesting channel and captures its payload in a
// one-entry output register, which cuts the long address/data path towards
// the slave. The slot refills on the same edge that it retires, so under
// continuous slave grant the block moves one transfer per cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   data_req_i        per-channel request
//   data_add_i        per-channel address
//   data_wen_i        per-channel write enable (1 = read)
//   data_wdata_i      per-channel write data
//   data_wtag_i       per-channel write tag
//   data_be_i         per-channel byte enable
//   data_ID_i         per-channel requester ID (passed through)
//   data_aux_i        per-channel auxiliary sideband
//   data_gnt_o        per-channel grant, one-hot or zero, combinational
//   data_req_o        request to slave (output slot valid)
//   data_*_o          registered payload of the last winner
//   data_gnt_i        grant from slave
// ---------------------------------------------------------------------------
module fanin_req_rr_arb_buffered #(
   parameter int N_CH       = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int BE_WIDTH   = DATA_WIDTH / 8,
   parameter int TAG_WIDTH  = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 16,
   parameter int AUX_WIDTH  = 32,
   parameter int PTR_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,

   input  logic [N_CH-1:0]                      data_req_i,
   input  logic [N_CH-1:0][ADDR_WIDTH-1:0]      data_add_i,
   input  logic [N_CH-1:0]                      data_wen_i,
   input  logic [N_CH-1:0][DATA_WIDTH-1:0]      data_wdata_i,
   input  logic [N_CH-1:0][TAG_WIDTH-1:0]       data_wtag_i,
   input  logic [N_CH-1:0][BE_WIDTH-1:0]        data_be_i,
   input  logic [N_CH-1:0][ID_WIDTH-1:0]        data_ID_i,
   input  logic [N_CH-1:0][AUX_WIDTH-1:0]       data_aux_i,
   output logic [N_CH-1:0]                      data_gnt_o,

   output logic                                 data_req_o,
   output logic [ADDR_WIDTH-1:0]                data_add_o,
   output logic                                 data_wen_o,
   output logic [DATA_WIDTH-1:0]                data_wdata_o,
   output logic [TAG_WIDTH-1:0]                 data_wtag_o,
   output logic [BE_WIDTH-1:0]                  data_be_o,
   output logic [ID_WIDTH-1:0]                  data_ID_o,
   output logic [AUX_WIDTH-1:0]                 data_aux_o,
   input  logic                                 data_gnt_i
);

   logic             valid_q;
   logic [PTR_W-1:0] rr_q;
   logic [PTR_W-1:0] rr_d;
   logic [PTR_W-1:0] win;
   logic             load;

   // Cyclic priority scan starting at rr_q. Non-power-of-two channel counts
   // wrap explicitly so the pointer never addresses a missing channel.
   always_comb begin
      int               idx;
      logic             found;
      logic [PTR_W-1:0] sel;
      // NOTE: every variable driven here gets a default before any branch,
      // otherwise paths that skip an assignment would infer a latch.
      win   = rr_q;
      found = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int i = 0; i < N_CH; i++) begin
         // NOTE: blocking '=' is correct inside combinational logic: each
         // iteration must see the value written by the previous one.
         idx = int'(rr_q) + i;
         if (idx >= N_CH) idx = idx - N_CH;
         sel = PTR_W'(idx);
         if (!found && data_req_i[sel]) begin
            win   = sel;
            found = 1'b1;
         end
      end
   end

   // The slot accepts a new entry when it is empty or retiring this cycle.
   // Gating with rst_n keeps input grants silent while reset is held.
   assign load = rst_n & (|data_req_i) & (~valid_q | data_gnt_i);

   assign rr_d = (win == PTR_W'(N_CH - 1)) ? '0 : win + PTR_W'(1);

   always_comb begin
      data_gnt_o = '0;
      for (int c = 0; c < N_CH; c++) begin
         data_gnt_o[c] = load && (win == PTR_W'(c));
      end
   end

   assign data_req_o = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the payload registers are reset too (not just valid_q) so
         // that every output reads zero while and after reset is asserted.
         valid_q      <= 1'b0;
         rr_q         <= '0;
         data_add_o   <= '0;
         data_wen_o   <= 1'b0;
         data_wdata_o <= '0;
         data_wtag_o  <= '0;
         data_be_o    <= '0;
         data_ID_o    <= '0;
         data_aux_o   <= '0;
      end else if (load) begin
         // NOTE: sequential state uses non-blocking '<=' so all registers
         // update together from pre-edge values.
         valid_q      <= 1'b1;
         rr_q         <= rr_d;
         data_add_o   <= data_add_i[win];
         data_wen_o   <= data_wen_i[win];
         data_wdata_o <= data_wdata_i[win];
         data_wtag_o  <= data_wtag_i[win];
         data_be_o    <= data_be_i[win];
         data_ID_o    <= data_ID_i[win];
         data_aux_o   <= data_aux_i[win];
      end else if (data_gnt_i) begin
         // Entry retires with nothing to replace it; payload holds.
         valid_q <= 1'b0;
      end
   end

endmodule
